clk_div_bank: RTL and testbench

Parametrised, fully synchronous clock-divider bank: CHANNELS independent divide-by-N channels driven from one clock. Each channel's ratio is programmable at run time through a valid/ready port, and a new ratio takes effect only at that channel's period boundary, so outputs never glitch. A masked AND of the channel outputs drives Y. The block replaces ripple-clocked toggle chains. Outputs are enable-style levels and pulses in the clk domain, not derived clocks.

---
 rtl/clk_div_bank_if.sv | 14 +
 rtl/clk_div_bank.sv | 108 ++++++++++
 tb/tb_clk_div_bank.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_bank_if.sv
// Divisor-write port of clk_div_bank. The requester drives the master modport
// and the divider bank drives the slave modport.
interface clk_div_bank_if #(
    parameter int DIV_W = 8,
    parameter int CH_W  = 2
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_chan, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_chan, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_bank.sv
// Bank of run-time programmable divide-by-N enable generators sharing one clock.
// Ratio changes wait for the channel's period boundary so the outputs never glitch.
module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                resync,
    clk_div_bank_if.slave       cfg,
    input  logic [CHANNELS-1:0] and_mask,
    output logic [CHANNELS-1:0] div_out,
    output logic [CHANNELS-1:0] tick,
    output logic                Y
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0]    r_n   [CHANNELS];
    logic [DIV_W-1:0]    r_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_div;
    logic [CHANNELS-1:0] r_tick;
    logic                r_pend_vld;
    logic [CH_W-1:0]     r_pend_chan;
    logic [DIV_W-1:0]    r_pend_n;

    logic [DIV_W-1:0]    w_n_nxt   [CHANNELS];
    logic [DIV_W-1:0]    w_cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_div_nxt;
    logic [CHANNELS-1:0] w_tick_nxt;
    logic [CHANNELS-1:0] w_wrap;
    logic [CHANNELS-1:0] w_apply;
    logic                w_accept;
    logic                w_in_range;

    // Divisors 0 and 1 cannot make a toggling output, so they run as /2.
    function automatic logic [DIV_W-1:0] f_clamp(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic f_high(input logic [DIV_W-1:0] cnt, input logic [DIV_W-1:0] n);
        logic [DIV_W:0] half;
        half = ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
        return {1'b0, cnt} < half;
    endfunction

    always_comb begin
        w_accept   = cfg.cfg_valid & ~r_pend_vld;
        w_in_range = int'(cfg.cfg_chan) < CHANNELS;
        w_div_nxt  = r_div;
        w_tick_nxt = '0;
        w_wrap     = '0;
        w_apply    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_wrap[i]    = (r_cnt[i] == (r_n[i] - ONE));
            // A pending ratio lands either on resync or exactly at the wrap to count 0.
            w_apply[i]   = r_pend_vld && (int'(r_pend_chan) == i) && (resync || (en && w_wrap[i]));
            w_n_nxt[i]   = w_apply[i] ? r_pend_n : r_n[i];
            w_cnt_nxt[i] = r_cnt[i];
            if (resync) begin
                w_cnt_nxt[i]  = w_n_nxt[i] - ONE;
                w_div_nxt[i]  = 1'b0;
                w_tick_nxt[i] = 1'b0;
            end else if (en) begin
                w_cnt_nxt[i]  = w_wrap[i] ? '0 : (r_cnt[i] + ONE);
                w_div_nxt[i]  = f_high(w_cnt_nxt[i], w_n_nxt[i]);
                w_tick_nxt[i] = (w_cnt_nxt[i] == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_n[i]   <= DIV_W'(2) << i;
                r_cnt[i] <= (DIV_W'(2) << i) - ONE;
            end
            r_div       <= '0;
            r_tick      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_chan <= '0;
            r_pend_n    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_n[i]   <= w_n_nxt[i];
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_div  <= w_div_nxt;
            r_tick <= w_tick_nxt;
            // Accept and clear are exclusive: accept needs an empty slot, clear a full one.
            if (|w_apply) begin
                r_pend_vld <= 1'b0;
            end else if (w_accept && w_in_range) begin
                r_pend_vld  <= 1'b1;
                r_pend_chan <= cfg.cfg_chan;
                r_pend_n    <= f_clamp(cfg.cfg_div);
            end
        end
    end

    assign cfg.cfg_ready = ~r_pend_vld;
    assign div_out       = r_div;
    assign tick          = r_tick;
    assign Y             = (|and_mask) & (&(r_div | ~and_mask));

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: default ratios, run-time loads, hold, mask,
// resync and asynchronous reset, against hand-derived waveforms.
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       resync = 1'b0;
    logic [3:0] and_mask = 4'b0;
    logic [3:0] div_out;
    logic [3:0] tick;
    logic       Y;

    logic       en2 = 1'b0;
    logic       resync2 = 1'b0;
    logic [4:0] mask2 = 5'b0;
    logic [4:0] div2;
    logic [4:0] tick2;
    logic       y2;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_bank_if #(.DIV_W(8), .CH_W(2)) cfg_if ();
    clk_div_bank_if #(.DIV_W(8), .CH_W(3)) cfg_if2 ();

    clk_div_bank #(.CHANNELS(4), .DIV_W(8), .CH_W(2)) dut (
        .clk(clk), .reset(reset), .en(en), .resync(resync), .cfg(cfg_if),
        .and_mask(and_mask), .div_out(div_out), .tick(tick), .Y(Y)
    );

    clk_div_bank #(.CHANNELS(5), .DIV_W(8), .CH_W(3)) dut5 (
        .clk(clk), .reset(reset), .en(en2), .resync(resync2), .cfg(cfg_if2),
        .and_mask(mask2), .div_out(div2), .tick(tick2), .Y(y2)
    );

    always #5 clk = ~clk;

    // Ideal waveform of a channel k enabled edges into a period of length n.
    function automatic logic [4:0] exp_div(input int k, input int n0, input int n1,
                                           input int n2, input int n3, input int n4);
        int n [5];
        logic [4:0] v;
        n = '{n0, n1, n2, n3, n4};
        for (int i = 0; i < 5; i++) v[i] = (k % n[i]) < ((n[i] + 1) / 2);
        return v;
    endfunction

    function automatic logic [4:0] exp_tick(input int k, input int n0, input int n1,
                                            input int n2, input int n3, input int n4);
        int n [5];
        logic [4:0] v;
        n = '{n0, n1, n2, n3, n4};
        for (int i = 0; i < 5; i++) v[i] = (k % n[i]) == 0;
        return v;
    endfunction

    task automatic do_reset();
        en = 1'b0; resync = 1'b0; en2 = 1'b0; resync2 = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if2.cfg_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        and_mask = 4'hF;
        #1;
        n_cmp++; if (div_out !== 4'b0) begin n_err++; $display("FAIL reset_div_out: got %b expected %b", div_out, 4'b0); end
        n_cmp++; if (tick !== 4'b0) begin n_err++; $display("FAIL reset_tick: got %b expected %b", tick, 4'b0); end
        n_cmp++; if (Y !== 1'b0) begin n_err++; $display("FAIL reset_Y: got %b expected 0", Y); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_default();
        logic [4:0] ed, et;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            ed = exp_div(k, 2, 4, 8, 16, 32);
            et = exp_tick(k, 2, 4, 8, 16, 32);
            n_cmp++; if (div_out !== ed[3:0]) begin n_err++; $display("FAIL default_div edge %0d: got %b expected %b", k, div_out, ed[3:0]); end
            n_cmp++; if (tick !== et[3:0]) begin n_err++; $display("FAIL default_tick edge %0d: got %b expected %b", k, tick, et[3:0]); end
        end
    endtask

    task automatic test_load();
        logic [0:7] t_div, t_tick, t_rdy;
        t_div  = 8'b0011_1001;
        t_tick = 8'b0010_0001;
        t_rdy  = 8'b0011_1111;
        do_reset();
        en = 1'b1;
        step();
        step();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_chan = 2'd1; cfg_if.cfg_div = 8'd5;
        for (int j = 0; j < 8; j++) begin
            step();
            if (j == 0) cfg_if.cfg_valid = 1'b0;
            n_cmp++; if (div_out[1] !== t_div[j]) begin n_err++; $display("FAIL load_div1 edge %0d: got %b expected %b", j + 2, div_out[1], t_div[j]); end
            n_cmp++; if (tick[1] !== t_tick[j]) begin n_err++; $display("FAIL load_tick1 edge %0d: got %b expected %b", j + 2, tick[1], t_tick[j]); end
            n_cmp++; if (cfg_if.cfg_ready !== t_rdy[j]) begin n_err++; $display("FAIL load_ready edge %0d: got %b expected %b", j + 2, cfg_if.cfg_ready, t_rdy[j]); end
        end
    endtask

    task automatic test_back_to_back();
        logic er, ed2, ed3, et2;
        do_reset();
        en = 1'b1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_chan = 2'd2; cfg_if.cfg_div = 8'd3;
        for (int e = 0; e < 22; e++) begin
            step();
            if (e == 0) begin cfg_if.cfg_chan = 2'd3; cfg_if.cfg_div = 8'd6; end
            er  = (e == 8) || (e >= 16);
            ed2 = (e < 8) ? ((e % 8) < 4) : (((e - 8) % 3) < 2);
            et2 = (e < 8) ? ((e % 8) == 0) : (((e - 8) % 3) == 0);
            ed3 = (e < 16) ? (e < 8) : (((e - 16) % 6) < 3);
            n_cmp++; if (cfg_if.cfg_ready !== er) begin n_err++; $display("FAIL b2b_ready edge %0d: got %b expected %b", e, cfg_if.cfg_ready, er); end
            n_cmp++; if (div_out[2] !== ed2) begin n_err++; $display("FAIL b2b_div2 edge %0d: got %b expected %b", e, div_out[2], ed2); end
            n_cmp++; if (tick[2] !== et2) begin n_err++; $display("FAIL b2b_tick2 edge %0d: got %b expected %b", e, tick[2], et2); end
            n_cmp++; if (div_out[3] !== ed3) begin n_err++; $display("FAIL b2b_div3 edge %0d: got %b expected %b", e, div_out[3], ed3); end
            if (e == 9) cfg_if.cfg_valid = 1'b0;
        end
    endtask

    task automatic test_clamp_discard();
        logic [0:9] t_div, t_tick, t_rdy;
        logic [4:0] ed, et;
        t_div  = 10'b1011_0101_01;
        t_tick = 10'b1010_0101_01;
        t_rdy  = 10'b0010_0111_11;
        do_reset();
        en = 1'b1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_chan = 2'd0; cfg_if.cfg_div = 8'd3;
        for (int e = 0; e < 10; e++) begin
            step();
            if (e == 0 || e == 3) cfg_if.cfg_valid = 1'b0;
            n_cmp++; if (div_out[0] !== t_div[e]) begin n_err++; $display("FAIL clamp_div0 edge %0d: got %b expected %b", e, div_out[0], t_div[e]); end
            n_cmp++; if (tick[0] !== t_tick[e]) begin n_err++; $display("FAIL clamp_tick0 edge %0d: got %b expected %b", e, tick[0], t_tick[e]); end
            n_cmp++; if (cfg_if.cfg_ready !== t_rdy[e]) begin n_err++; $display("FAIL clamp_ready edge %0d: got %b expected %b", e, cfg_if.cfg_ready, t_rdy[e]); end
            if (e == 2) begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd0; end
        end
        do_reset();
        en2 = 1'b1;
        cfg_if2.cfg_valid = 1'b1; cfg_if2.cfg_chan = 3'd5; cfg_if2.cfg_div = 8'd3;
        for (int k = 0; k < 32; k++) begin
            step();
            if (k == 0) cfg_if2.cfg_valid = 1'b0;
            ed = exp_div(k, 2, 4, 8, 16, 32);
            et = exp_tick(k, 2, 4, 8, 16, 32);
            n_cmp++; if (cfg_if2.cfg_ready !== 1'b1) begin n_err++; $display("FAIL discard_ready edge %0d: got %b expected 1", k, cfg_if2.cfg_ready); end
            n_cmp++; if (div2 !== ed) begin n_err++; $display("FAIL discard_div edge %0d: got %b expected %b", k, div2, ed); end
            n_cmp++; if (tick2 !== et) begin n_err++; $display("FAIL discard_tick edge %0d: got %b expected %b", k, tick2, et); end
        end
        n_cmp++; if (y2 !== 1'b0) begin n_err++; $display("FAIL discard_Y_nomask: got %b expected 0", y2); end
        en2 = 1'b0;
    endtask

    task automatic test_hold();
        logic [4:0] ed, et;
        do_reset();
        en = 1'b1;
        repeat (5) step();
        en = 1'b0;
        for (int h = 0; h < 7; h++) begin
            step();
            n_cmp++; if (div_out !== 4'b1011) begin n_err++; $display("FAIL hold_div cycle %0d: got %b expected %b", h, div_out, 4'b1011); end
            n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL hold_tick cycle %0d: got %b expected %b", h, tick, 4'b0000); end
        end
        en = 1'b1;
        for (int k = 5; k < 13; k++) begin
            step();
            ed = exp_div(k, 2, 4, 8, 16, 32);
            et = exp_tick(k, 2, 4, 8, 16, 32);
            n_cmp++; if (div_out !== ed[3:0]) begin n_err++; $display("FAIL resume_div edge %0d: got %b expected %b", k, div_out, ed[3:0]); end
            n_cmp++; if (tick !== et[3:0]) begin n_err++; $display("FAIL resume_tick edge %0d: got %b expected %b", k, tick, et[3:0]); end
        end
    endtask

    task automatic test_mask();
        logic [0:7] t_y;
        t_y = 8'b1010_0000;
        do_reset();
        and_mask = 4'b0000;
        en = 1'b1;
        step();
        n_cmp++; if (Y !== 1'b0) begin n_err++; $display("FAIL mask_zero_Y: got %b expected 0", Y); end
        and_mask = 4'b1111;
        #1;
        n_cmp++; if (Y !== 1'b1) begin n_err++; $display("FAIL mask_all_Y: got %b expected 1", Y); end
        and_mask = 4'b0101;
        #1;
        n_cmp++; if (Y !== 1'b1) begin n_err++; $display("FAIL mask_0101_Y edge 0: got %b expected 1", Y); end
        for (int k = 1; k < 17; k++) begin
            step();
            n_cmp++; if (Y !== t_y[k % 8]) begin n_err++; $display("FAIL mask_0101_Y edge %0d: got %b expected %b", k, Y, t_y[k % 8]); end
        end
    endtask

    task automatic test_resync();
        logic [4:0] ed, et;
        do_reset();
        en = 1'b1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_chan = 2'd1; cfg_if.cfg_div = 8'd3;
        for (int e = 0; e < 7; e++) begin
            step();
            if (e == 0) cfg_if.cfg_valid = 1'b0;
            if (e == 5) begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_chan = 2'd0; cfg_if.cfg_div = 8'd5; end
        end
        cfg_if.cfg_valid = 1'b0;
        n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL resync_pending_ready: got %b expected 0", cfg_if.cfg_ready); end
        resync = 1'b1;
        step();
        resync = 1'b0;
        n_cmp++; if (div_out !== 4'b0) begin n_err++; $display("FAIL resync_div: got %b expected %b", div_out, 4'b0); end
        n_cmp++; if (tick !== 4'b0) begin n_err++; $display("FAIL resync_tick: got %b expected %b", tick, 4'b0); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL resync_ready: got %b expected 1", cfg_if.cfg_ready); end
        for (int k = 0; k < 15; k++) begin
            step();
            ed = exp_div(k, 5, 3, 8, 16, 32);
            et = exp_tick(k, 5, 3, 8, 16, 32);
            n_cmp++; if (div_out !== ed[3:0]) begin n_err++; $display("FAIL realign_div edge %0d: got %b expected %b", k, div_out, ed[3:0]); end
            n_cmp++; if (tick !== et[3:0]) begin n_err++; $display("FAIL realign_tick edge %0d: got %b expected %b", k, tick, et[3:0]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        and_mask = 4'hF;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_chan = 2'd3; cfg_if.cfg_div = 8'd9;
        step();
        cfg_if.cfg_valid = 1'b0;
        n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL pre_reset_ready: got %b expected 0", cfg_if.cfg_ready); end
        n_cmp++; if (div_out !== 4'hF) begin n_err++; $display("FAIL pre_reset_div: got %b expected %b", div_out, 4'hF); end
        n_cmp++; if (Y !== 1'b1) begin n_err++; $display("FAIL pre_reset_Y: got %b expected 1", Y); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (div_out !== 4'b0) begin n_err++; $display("FAIL async_reset_div: got %b expected %b", div_out, 4'b0); end
        n_cmp++; if (tick !== 4'b0) begin n_err++; $display("FAIL async_reset_tick: got %b expected %b", tick, 4'b0); end
        n_cmp++; if (Y !== 1'b0) begin n_err++; $display("FAIL async_reset_Y: got %b expected 0", Y); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_ready: got %b expected 1", cfg_if.cfg_ready); end
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0; cfg_if.cfg_chan  = '0; cfg_if.cfg_div  = '0;
        cfg_if2.cfg_valid = 1'b0; cfg_if2.cfg_chan = '0; cfg_if2.cfg_div = '0;
        test_reset();
        test_default();
        test_load();
        test_back_to_back();
        test_clamp_discard();
        test_hold();
        test_mask();
        test_resync();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
